// File: rtl/debounce_bank_if.sv
// Signal bundle for debounce_bank: count qualifier, raw pins and debounced outputs.
// The master side drives pins/tick; the debouncer is the slave.
interface debounce_bank_if #(
  parameter int unsigned CHANNELS = 4
);
  logic                tick;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] dout;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic                any_event;

  modport master (
    output tick, din,
    input  dout, rise, fall, any_event
  );

  modport slave (
    input  tick, din,
    output dout, rise, fall, any_event
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: per-channel synchroniser, stability counter gated by tick,
// registered debounced level with one-cycle rise/fall strobes and a combined event flag.
module debounce_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned COUNT_MAX   = 2**16-1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_LEVEL = 1'b0
) (
  input logic            clk,
  input logic            rst,
  debounce_bank_if.slave bus
);

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(COUNT_MAX);

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_q  [CHANNELS];
  logic [COUNT_WIDTH-1:0] cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    s;
  logic [CHANNELS-1:0]    dout_q, dout_d;
  logic [CHANNELS-1:0]    rise_q, rise_d;
  logic [CHANNELS-1:0]    fall_q, fall_d;
  logic                   any_q;

  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // STABLE/PENDING is implied by s != dout; no explicit state register is kept.
  always_comb begin
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (s[i] != dout_q[i]) begin
        cnt_d[i] = cnt_q[i];
        if (bus.tick) begin
          if (cnt_q[i] == CNT_LAST) begin
            cnt_d[i]  = '0;
            dout_d[i] = s[i];
            rise_d[i] = s[i];
            fall_d[i] = ~s[i];
          end else begin
            cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {SYNC_STAGES{RESET_LEVEL}};
        cnt_q[i]  <= '0;
      end
      dout_q <= {CHANNELS{RESET_LEVEL}};
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.din[i]};
        cnt_q[i]  <= cnt_d[i];
      end
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      // Built from next-state strobes so the flag lands in the same cycle as them.
      any_q  <= |(rise_d | fall_d);
    end
  end

  assign bus.dout      = dout_q;
  assign bus.rise      = rise_q;
  assign bus.fall      = fall_q;
  assign bus.any_event = any_q;

endmodule
